// File: rtl/iob_sram_loader_pkg.sv
// Shared FSM encoding and strobe constants for the IOb SRAM loader.
// Imported by iob_sram_loader and iob_sram_loader_cnt.
package iob_sram_loader_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE        = 3'd0,
    WRITE       = 3'd1,
    VERIFY_REQ  = 3'd2,
    VERIFY_WAIT = 3'd3,
    DONE        = 3'd4
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam logic [DEF_DATA_W/8-1:0] WSTRB_ALL = {DEF_DATA_W/8{1'b1}};

endpackage

// File: rtl/iob_sram_loader_cnt.sv
// Word index counter shared by the write and readback passes: latches base/len
// on load, produces the wrapped word address and flags the last word.
module iob_sram_loader_cnt
  import iob_sram_loader_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              cke,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic              inc,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else if (cke) begin
      if (load) begin
        base_q <= base;
        len_q  <= len;
        idx_q  <= '0;
      end else if (clr) begin
        idx_q <= '0;
      end else if (inc) begin
        idx_q <= idx_q + ONE;
      end
    end
  end

  // Dropping the index MSB makes the address wrap modulo 2^ADDR_W.
  assign addr = base_q + idx_q[ADDR_W-1:0];
  assign last = (idx_q == (len_q - ONE));

endmodule

// File: rtl/iob_sram_loader.sv
// IOb initiator that fills a word-addressed SRAM from a valid/ready stream.
// Readback verify pass is built in with IOB_SRAM_LOADER_VERIFY_EN.
// state | meaning: IDLE wait start | WRITE stream->sram | VERIFY_REQ issue read | VERIFY_WAIT await rdata | DONE one-cycle done pulse
module iob_sram_loader
  import iob_sram_loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_i,
  input  logic [ADDR_W:0]     len_i,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic                m_avalid_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic                m_rvalid_i,
  input  logic                m_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [DATA_W-1:0]   sum_o,
  output logic                err_o
);

  localparam logic [DATA_W/8-1:0] STRB_ONES = '1;

  state_t state_q, state_d;

  logic              start_ok;
  logic              wr_xfer;
  logic              clr_idx;
  logic              inc_idx;
  logic              last;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] sum_q;

  assign start_ok = cke_i & start_i & (state_q == IDLE);
  assign wr_xfer  = cke_i & (state_q == WRITE) & s_valid_i & m_ready_i;

  iob_sram_loader_cnt #(
    .ADDR_W(ADDR_W)
  ) u_cnt (
    .clk  (clk_i),
    .cke  (cke_i),
    .rst  (rst_i),
    .load (start_ok),
    .clr  (clr_idx),
    .inc  (inc_idx),
    .base (base_i),
    .len  (len_i),
    .addr (addr),
    .last (last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else if (cke_i) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    m_avalid_o = 1'b0;
    m_wdata_o  = '0;
    m_wstrb_o  = '0;
    s_ready_o  = 1'b0;
    clr_idx    = 1'b0;
    inc_idx    = wr_xfer;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (len_i == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        m_avalid_o = cke_i & s_valid_i;
        m_wdata_o  = s_data_i;
        m_wstrb_o  = STRB_ONES;
        s_ready_o  = cke_i & m_ready_i;
        if (wr_xfer && last) begin
`ifdef IOB_SRAM_LOADER_VERIFY_EN
          state_d = VERIFY_REQ;
          clr_idx = 1'b1;
          inc_idx = 1'b0;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef IOB_SRAM_LOADER_VERIFY_EN
      VERIFY_REQ: begin
        m_avalid_o = cke_i;
        if (m_ready_i) begin
          state_d = VERIFY_WAIT;
        end
      end
      VERIFY_WAIT: begin
        if (m_rvalid_i) begin
          inc_idx = 1'b1;
          state_d = last ? DONE : VERIFY_REQ;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else if (cke_i) begin
      if (start_ok) begin
        sum_q <= '0;
      end else if (wr_xfer) begin
        sum_q <= sum_q + s_data_i;
      end
    end
  end

`ifdef IOB_SRAM_LOADER_VERIFY_EN
  logic [DATA_W-1:0] rb_sum_q;
  logic [DATA_W-1:0] rb_sum_d;
  logic              rd_beat;
  logic              err_q;

  assign rd_beat  = (state_q == VERIFY_WAIT) & m_rvalid_i;
  assign rb_sum_d = rb_sum_q + m_rdata_i;

  // The compare uses the sum including the final beat so err_o is valid in DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rb_sum_q <= '0;
      err_q    <= 1'b0;
    end else if (cke_i) begin
      if (start_ok) begin
        rb_sum_q <= '0;
        err_q    <= 1'b0;
      end else if (rd_beat) begin
        rb_sum_q <= rb_sum_d;
        if (last) begin
          err_q <= (rb_sum_d != sum_q);
        end
      end
    end
  end

  assign err_o = err_q;
`else
  logic unused_rd;
  assign unused_rd = ^{m_rdata_i, m_rvalid_i};
  assign err_o     = 1'b0;
`endif

  assign m_addr_o = addr;
  assign sum_o    = sum_q;
  assign busy_o   = (state_q == WRITE) | (state_q == VERIFY_REQ) | (state_q == VERIFY_WAIT);
  assign done_o   = (state_q == DONE);

endmodule

// File: tb/tb_iob_sram_loader.sv
// Self-checking bench for iob_sram_loader: vector table of loads, write scoreboard,
// SRAM responder model; reset-abort and readback (IOB_SRAM_LOADER_VERIFY_EN) sequences.
module tb_iob_sram_loader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 13;

  logic              clk_i = 1'b0;
  logic              cke_i;
  logic              rst_i;
  logic              start_i;
  logic [ADDR_W-1:0] base_i;
  logic [ADDR_W:0]   len_i;
  logic [DATA_W-1:0] s_data_i;
  logic              s_valid_i;
  logic              s_ready_o;
  logic              m_avalid_o;
  logic [ADDR_W-1:0] m_addr_o;
  logic [DATA_W-1:0] m_wdata_o;
  logic [3:0]        m_wstrb_o;
  logic [DATA_W-1:0] m_rdata_i;
  logic              m_rvalid_i;
  logic              m_ready_i;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] sum_o;
  logic              err_o;

  always #5 clk_i = ~clk_i;

  iob_sram_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .start_i(start_i),
    .base_i(base_i), .len_i(len_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o), .m_avalid_o(m_avalid_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_rdata_i(m_rdata_i),
    .m_rvalid_i(m_rvalid_i), .m_ready_i(m_ready_i), .busy_o(busy_o),
    .done_o(done_o), .sum_o(sum_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [12:0]      base;
    logic [13:0]      len;
    logic [7:0]       stall_at;
    logic [7:0]       stall_n;
    logic [31:0]      sum;
    logic [7:0][31:0] data;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int n_rd = 0;
  int rd_start = 0;
  int rd_wait = 0;
  logic [12:0] rd_base = '0;
  logic [12:0] rd_addr = '0;
  logic [13:0] corrupt = 14'h2000;
  logic [31:0] mem [0:8191];
  logic [44:0] sb_q [$];
  vec_t vecs [6];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // SRAM responder: commits writes, checks them against the scoreboard, answers reads after 2 cycles.
  always @(negedge clk_i) begin
    logic [44:0] e;
    m_rvalid_i = 1'b0;
    if (rd_wait > 0) begin
      rd_wait--;
      if (rd_wait == 0) begin
        m_rvalid_i = 1'b1;
        m_rdata_i  = mem[rd_addr] ^ ((!corrupt[13] && rd_addr == corrupt[12:0]) ? 32'h1 : 32'h0);
      end
    end
    if (!rst_i && m_avalid_o && m_ready_i) begin
      if (m_wstrb_o != 4'h0) begin
        mem[m_addr_o] = m_wdata_o;
        check("wr_strb", m_wstrb_o, 4'hF);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: addr %0h data %0h with empty scoreboard", m_addr_o, m_wdata_o);
        end else begin
          e = sb_q.pop_front();
          check("wr_addr", m_addr_o, e[44:32]);
          check("wr_data", m_wdata_o, e[31:0]);
        end
      end else begin
        check("rd_addr", m_addr_o, 13'(rd_base + 13'(n_rd - rd_start)));
        n_rd++;
        rd_addr = m_addr_o;
        rd_wait = 2;
      end
    end
  end

  function automatic int exp_lat(input vec_t v);
`ifdef IOB_SRAM_LOADER_VERIFY_EN
    return (v.len == 0) ? 1 : 4 * int'(v.len) + 1 + int'(v.stall_n);
`else
    return int'(v.len) + 1 + int'(v.stall_n);
`endif
  endfunction

  task automatic run_load(input vec_t v, input logic exp_err);
    int idx, cyc, lat, pushed;
    bit seen;
    idx = 0; cyc = 0; lat = 0; pushed = -1; seen = 0;
    rd_base  = v.base;
    rd_start = n_rd;
    @(posedge clk_i); #1;
    start_i = 1'b1; base_i = v.base; len_i = v.len;
    @(posedge clk_i); #1;
    cyc = 1;
    while (!seen && cyc < 400) begin
      start_i   = 1'b1;
      s_valid_i = (idx < int'(v.len));
      s_data_i  = v.data[idx[2:0]];
      if (s_valid_i && pushed != idx) begin
        sb_q.push_back({13'(v.base + 13'(idx)), v.data[idx[2:0]]});
        pushed = idx;
      end
      m_ready_i = !(cyc >= int'(v.stall_at) && cyc < int'(v.stall_at) + int'(v.stall_n));
      @(negedge clk_i);
      if (!m_ready_i && s_valid_i) begin
        check("stall_s_ready", s_ready_o, 1'b0);
        check("stall_avalid", m_avalid_o, 1'b1);
        check("stall_addr", m_addr_o, 13'(v.base + 13'(idx)));
        check("stall_wdata", m_wdata_o, v.data[idx[2:0]]);
      end
      if (done_o) begin
        seen = 1;
        lat  = cyc;
        check("done_busy", busy_o, 1'b0);
        check("done_avalid", m_avalid_o, 1'b0);
        check("done_sum", sum_o, v.sum);
        check("done_err", err_o, exp_err);
      end
      if (s_valid_i && s_ready_o) idx++;
      @(posedge clk_i); #1;
      cyc++;
    end
    start_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b1;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done_o within %0d cycles (base %0h len %0d)", cyc, v.base, v.len);
    end else begin
      check("done_latency", lat, exp_lat(v));
    end
    @(negedge clk_i);
    check("after_done_busy", busy_o, 1'b0);
    check("after_done_avalid", m_avalid_o, 1'b0);
    check("after_done_sum_hold", sum_o, v.sum);
    check("sb_empty", sb_q.size(), 0);
    for (int i = 0; i < int'(v.len); i++) begin
      check("mem_image", mem[13'(v.base + 13'(i))], v.data[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cke_i = 1'b1; rst_i = 1'b1; start_i = 1'b0; base_i = '0; len_i = '0;
    s_data_i = '0; s_valid_i = 1'b0; m_ready_i = 1'b1;
    m_rdata_i = '0; m_rvalid_i = 1'b0;

    for (int i = 0; i < 6; i++) vecs[i] = '0;
    vecs[0].base = 13'h10;   vecs[0].len = 14'd4; vecs[0].sum = 32'hA;
    vecs[0].data[0] = 32'h1; vecs[0].data[1] = 32'h2; vecs[0].data[2] = 32'h3; vecs[0].data[3] = 32'h4;
    vecs[1].base = 13'h55;   vecs[1].len = 14'd0; vecs[1].sum = 32'h0;
    vecs[2].base = 13'h1FFF; vecs[2].len = 14'd2; vecs[2].sum = 32'h1;
    vecs[2].data[0] = 32'hFFFF_FFFF; vecs[2].data[1] = 32'h2;
    vecs[3].base = 13'h100;  vecs[3].len = 14'd6; vecs[3].sum = 32'h165;
    vecs[3].stall_at = 8'd3; vecs[3].stall_n = 8'd3;
    for (int i = 0; i < 6; i++) vecs[3].data[i] = 32'h11 * (i + 1);
    vecs[4].base = 13'h0;    vecs[4].len = 14'd1; vecs[4].sum = 32'hDEAD_BEEF;
    vecs[4].data[0] = 32'hDEAD_BEEF;
    vecs[5].base = 13'h200;  vecs[5].len = 14'd5; vecs[5].sum = 32'hF;
    for (int i = 0; i < 5; i++) vecs[5].data[i] = i + 1;

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_avalid", m_avalid_o, 1'b0);
    check("rst_s_ready", s_ready_o, 1'b0);
    check("rst_sum", sum_o, 32'h0);
    check("rst_err", err_o, 1'b0);
    check("rst_wstrb", m_wstrb_o, 4'h0);

    for (int v = 0; v < 5; v++) run_load(vecs[v], 1'b0);

    // Abort a load after two of five words with a one-cycle reset.
    @(posedge clk_i); #1;
    start_i = 1'b1; base_i = 13'h200; len_i = 14'd5;
    @(posedge clk_i); #1;
    start_i = 1'b0; s_valid_i = 1'b1; s_data_i = 32'h1;
    sb_q.push_back({13'h200, 32'h1});
    @(posedge clk_i); #1;
    s_data_i = 32'h2;
    sb_q.push_back({13'h201, 32'h2});
    @(posedge clk_i); #1;
    s_valid_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    check("abort_sum_partial", sum_o, 32'h3);
    check("abort_busy_before", busy_o, 1'b1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("abort_avalid", m_avalid_o, 1'b0);
    check("abort_busy", busy_o, 1'b0);
    check("abort_sum", sum_o, 32'h0);
    check("abort_s_ready", s_ready_o, 1'b0);
    check("abort_done", done_o, 1'b0);
    check("abort_sb_empty", sb_q.size(), 0);
    run_load(vecs[5], 1'b0);

`ifdef IOB_SRAM_LOADER_VERIFY_EN
    rd_start = n_rd;
    corrupt = {1'b0, 13'h12};
    run_load(vecs[0], 1'b1);
    check("verify_reads_corrupt", n_rd - rd_start, 4);
    corrupt = 14'h2000;
    rd_start = n_rd;
    run_load(vecs[0], 1'b0);
    check("verify_reads_clean", n_rd - rd_start, 4);
`else
    check("no_reads", n_rd, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
